// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch-stage state and the IF/ID layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    // IF/ID pipeline register layout, shared with the decode stage.
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from the icache,
// absorbs one fetched word while decode is stalled, applies redirects and
// parks in HALTED once a halt instruction reaches IF/ID.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr_out,
    output word_t pc_out,
    output word_t npc_out,
    output logic  instr_valid,
    output logic  halted
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    if_id_t       ifid_q, ifid_d;
    word_t        buf_instr_q, buf_instr_d;
    word_t        buf_pc_q, buf_pc_d;
    logic         buf_load;

    // Next-state logic: redirect beats halt beats normal fetch/hold flow.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_load    = 1'b0;

        if (state_q != HALTED) begin
            if (redirect) begin
                // The redirect flushes IF/ID and any buffered word; the
                // target is forced word-aligned.
                pc_d         = redirect_pc & 32'hFFFF_FFFC;
                ifid_d.valid = 1'b0;
                state_d      = FETCH;
            end else if (halt && ifid_q.valid) begin
                ifid_d.valid = 1'b0;
                state_d      = HALTED;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (ihit) begin
                            pc_d = pc_q + PC_STEP;
                            if (stall) begin
                                buf_load    = 1'b1;
                                buf_instr_d = iload;
                                buf_pc_d    = pc_q;
                                state_d     = HOLD;
                            end else begin
                                ifid_d = '{instr: iload, pc: pc_q,
                                           npc: pc_q + PC_STEP, valid: 1'b1};
                            end
                        end else if (!stall) begin
                            ifid_d.valid = 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            ifid_d  = '{instr: buf_instr_q, pc: buf_pc_q,
                                        npc: buf_pc_q + PC_STEP, valid: 1'b1};
                            state_d = FETCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            ifid_q  <= '{instr: '0, pc: '0, npc: PC_STEP, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    // Hold buffer data; only meaningful while in HOLD, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (buf_load) begin
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign iREN        = (state_q == FETCH);
    assign iaddr       = pc_q;
    assign instr_out   = ifid_q.instr;
    assign pc_out      = ifid_q.pc;
    assign npc_out     = ifid_q.npc;
    assign instr_valid = ifid_q.valid;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic  CLK = 1'b0;
    logic  RST, ihit, stall, redirect, halt;
    word_t iload, redirect_pc;
    logic  iREN, instr_valid, halted;
    word_t iaddr, instr_out, pc_out, npc_out;

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
        .iaddr(iaddr), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .instr_out(instr_out),
        .pc_out(pc_out), .npc_out(npc_out), .instr_valid(instr_valid),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  iren;
        word_t iaddr;
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
        logic  halted;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: fetch pointer, queue of fetched-but-undelivered words,
    // the word presented to decode, and a sticky halt flag.
    word_t m_pc, m_if_instr, m_if_pc;
    logic  m_if_valid, m_halt;
    word_t pend_instr[$];
    word_t pend_pc[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic hit, input word_t load,
                                input logic stl, input logic rdr, input word_t rpc,
                                input logic hlt);
        if (rst) begin
            m_pc = PC_INIT; m_if_instr = 0; m_if_pc = 0; m_if_valid = 0; m_halt = 0;
            pend_instr.delete(); pend_pc.delete();
        end else if (m_halt) begin
            // frozen until reset
        end else if (rdr) begin
            m_pc = {rpc[31:2], 2'b00};
            m_if_valid = 0;
            pend_instr.delete(); pend_pc.delete();
        end else if (hlt && m_if_valid) begin
            m_halt = 1; m_if_valid = 0;
        end else if (pend_pc.size() > 0) begin
            if (!stl) begin
                m_if_instr = pend_instr.pop_front();
                m_if_pc    = pend_pc.pop_front();
                m_if_valid = 1;
            end
        end else if (hit) begin
            if (stl) begin
                pend_instr.push_back(load);
                pend_pc.push_back(m_pc);
            end else begin
                m_if_instr = load; m_if_pc = m_pc; m_if_valid = 1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stl) begin
            m_if_valid = 0;
        end
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.iren   = !m_halt && (pend_pc.size() == 0);
        e.iaddr  = m_pc;
        e.instr  = m_if_instr;
        e.pc     = m_if_pc;
        e.npc    = m_if_pc + 32'd4;
        e.valid  = m_if_valid;
        e.halted = m_halt;
        return e;
    endfunction

    // Drive one cycle of stimulus, advance the model, queue the expected outputs.
    task automatic step(input logic rst, input logic hit, input word_t load,
                        input logic stl, input logic rdr, input word_t rpc,
                        input logic hlt);
        RST = rst; ihit = hit; iload = load; stall = stl;
        redirect = rdr; redirect_pc = rpc; halt = hlt;
        model_update(rst, hit, load, stl, rdr, rpc, hlt);
        @(posedge CLK);
        sb.push_back(expected());
        @(negedge CLK);
    endtask

    // Monitor: compare registered outputs against the oldest expectation.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("iREN",        word_t'(iREN),        word_t'(e.iren));
            check("iaddr",       iaddr,                e.iaddr);
            check("instr_valid", word_t'(instr_valid), word_t'(e.valid));
            check("instr_out",   instr_out,            e.instr);
            check("pc_out",      pc_out,               e.pc);
            check("npc_out",     npc_out,              e.npc);
            check("halted",      word_t'(halted),      word_t'(e.halted));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1; ihit = 0; iload = 0; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        @(negedge CLK);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        // halt with no live instruction is ignored
        step(0, 0, 0, 0, 0, 0, 1);
        // streaming hits, then a 3-cycle miss at PC 8
        step(0, 1, 32'h2001_0005, 0, 0, 0, 0);
        step(0, 1, 32'h2002_0007, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'hBAD0_0000, 0, 0, 0, 0);
        step(0, 1, 32'h2003_0009, 0, 0, 0, 0);
        // stall with a hit at PC 0xC goes to HOLD, then drains
        step(0, 1, 32'h2004_000B, 1, 0, 0, 0);
        step(0, 1, 32'hBAD1_0000, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h2005_000D, 0, 0, 0, 0);
        // redirect during hit+stall drops everything, aligns target
        step(0, 1, 32'hBAD2_0000, 1, 1, 32'h0000_0043, 0);
        step(0, 1, 32'h2006_000F, 0, 0, 0, 0);
        // redirect beats same-cycle halt
        step(0, 1, 32'hBAD3_0000, 0, 1, 32'h0000_0100, 1);
        step(0, 1, 32'h2007_0011, 0, 0, 0, 0);
        step(0, 1, 32'h2008_0013, 0, 0, 0, 0);
        // halt on a live instruction, then everything is ignored
        step(0, 1, 32'hBAD4_0000, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h2009_0015, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 70),
                 $urandom,
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 5),
                 $urandom,
                 ($urandom_range(0, 99) < 3));
        end
        repeat (2) @(negedge CLK);
        #1;
        check("scoreboard_drain", word_t'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of control_unit.
- Owns the PC and issues instruction reads to the icache (iREN/iaddr, ihit/iload).
- Latches each fetched word into an IF/ID register whose instr_out drives control_unit Instr.
- Handles downstream stalls with a one-entry hold buffer, applies redirects (jump/branch) from later stages, and stops fetching on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  one clock; reset is synchronous and active-high
- ihit  in  1  icache returns valid iload this cycle
- iload  in  32  instruction word from icache
- iREN  out  1  instruction read request
- iaddr  out  32  instruction address (= PC)
- stall  in  1  hazard unit: IF/ID must hold its contents
- redirect  in  1  resolved jump/taken branch from a later stage
- redirect_pc  in  32  target PC when redirect=1
- halt  in  1  control_unit decoded halt on the valid IF/ID instruction
- instr_out  out  32  IF/ID instruction; feeds control_unit Instr
- pc_out  out  32  PC of instr_out
- npc_out  out  32  pc_out+4; used for JAL PcToReg
- instr_valid  out  1  IF/ID holds a live instruction
- halted  out  1  sticky halt indication

Behaviour:
- Reset (RST=1 at a CLK edge):
  - PC=PC_INIT, state=FETCH.
  - instr_out=0, pc_out=0, npc_out=4, instr_valid=0, halted=0.
  - Hold buffer is emptied.
  - Reset mid-miss discards the pending fetch; the first request after reset is iaddr=PC_INIT.
- iaddr=PC at all times.
- iREN=1 only in state FETCH. iREN=0 in HOLD and HALTED.
- Arithmetic: PC+4 wraps mod 2^32. redirect_pc[1:0] is forced to 2'b00 when loaded.
- States are FETCH, HOLD and HALTED. Priority each cycle is RST > redirect > halt > normal.
- FETCH:
  - ihit=1 & stall=0: IF/ID <= {iload, PC, PC+4}, instr_valid<=1, PC<=PC+4. Zero-bubble throughput: one instruction per hit cycle.
  - ihit=1 & stall=1: buffer <= {iload, PC}, PC<=PC+4, go to HOLD. IF/ID is unchanged.
  - ihit=0 & stall=0: instr_valid<=0 (bubble). PC is unchanged and iREN stays asserted.
  - ihit=0 & stall=1: IF/ID and PC are unchanged.
- HOLD:
  - stall=1: nothing changes.
  - stall=0: IF/ID <= buffer (valid=1), return to FETCH. The next request issues in the following cycle.
- redirect=1, any state except HALTED:
  - PC<=redirect_pc, instr_valid<=0, buffer discarded, state<=FETCH.
  - A same-cycle ihit is discarded.
  - Redirect overrides stall.
  - Redirect wins over a same-cycle halt, because the halt instruction is younger and is flushed.
- halt=1 & redirect=0:
  - state<=HALTED, instr_valid<=0, halted<=1.
  - A same-cycle ihit is discarded.
- HALTED: absorbing until RST. iREN=0, PC frozen; redirect, stall and ihit are ignored.
- halt is only honoured while instr_valid=1. halt asserted with instr_valid=0 is ignored.
- Outputs are registered. No combinational path from ihit/iload to instr_out.

Decomposition:
- cpu_types_pkg:
  - Add fetch_state_t enum {FETCH, HOLD, HALTED}.
  - Add localparam word_t PC_STEP=4.
  - Reuse word_t for every 32-bit field.
- Optionally add an if_id_t packed struct {instr, pc, npc, valid} so the downstream stage shares the layout.
- Single module. No sub-module is warranted: the hold buffer is one register and does not merit its own block.

Test Plan:
- Reset then ihit=1 every cycle, iload=32'h2001_0005,32'h2002_0007,... -> iaddr 0,4,8; instr_out follows one cycle later, pc_out=0/npc_out=4 first, instr_valid=1 continuous.
- Cache miss: ihit=0 for 3 cycles at PC=8 -> iREN=1, iaddr=8 held, instr_valid=0 for those cycles, then instr_out=iload with pc_out=8.
- stall=1 arriving with ihit at PC=0xC -> state HOLD, iREN=0, IF/ID unchanged. After stall drops, instr_out=buffered word with pc_out=0xC, then iaddr=0x10.
- redirect=1 with redirect_pc=32'h0000_0043 during ihit+stall -> next iaddr=0x40, instr_valid=0, buffer dropped, next captured pc_out=0x40.
- halt=1 with redirect=0 at instr_valid=1 -> halted=1, iREN=0 thereafter, redirect/ihit ignored for 10 cycles. RST=1 -> iaddr=PC_INIT, halted=0.
- Same-cycle halt=1 & redirect=1 -> no halt, PC=redirect_pc, fetching continues.
